// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge
// AXI3 master bridge between the CPU's SRAM-like instruction/data ports and
// the AXI bus. One read engine (instruction line fills of BURST_LEN beats and
// single-beat data reads) and one independent write engine (single-beat data
// writes). Data reads win read arbitration over instruction fills.
//
// Optional feature macro: AXI_BRIDGE_WRAP_EN
//   defined     : instruction fills are WRAP bursts starting at the
//                 word-aligned request address (critical word first)
//   not defined : instruction fills are INCR bursts from the line-aligned
//                 address
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   inst_*                 instruction fill request / return
//   data_*                 data request / read return / write completion
//   ar*, r*, aw*, w*, b*   AXI3 master channels
//   o_dbg_rd_state         read FSM state (R_IDLE=0, R_AR=1, R_DATA=2)
//   o_dbg_wr_state         write FSM state (W_IDLE=0, W_SEND=1, W_B=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; a master holds valid and all payload fields stable until then.
module cpu_axi_bridge #(
    parameter int BURST_LEN = 8,
    parameter int ID_W      = 4
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            inst_req,
    input  logic [31:0]     inst_addr,
    output logic            inst_addr_ok,
    output logic [31:0]     inst_rdata,
    output logic            inst_rvalid,
    output logic            inst_rlast,
    input  logic            data_req,
    input  logic            data_wr,
    input  logic [1:0]      data_size,
    input  logic [31:0]     data_addr,
    input  logic [31:0]     data_wdata,
    input  logic [3:0]      data_wstrb,
    output logic            data_addr_ok,
    output logic [31:0]     data_rdata,
    output logic            data_rvalid,
    output logic            data_wdone,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [3:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [1:0]      arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [3:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic [1:0]      awlock,
    output logic [3:0]      awcache,
    output logic [2:0]      awprot,
    output logic            awvalid,
    input  logic            awready,
    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready,
    output logic [1:0]      o_dbg_rd_state,
    output logic [1:0]      o_dbg_wr_state
);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} rd_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_B = 2'd2} wr_state_t;

    localparam logic [3:0]  INST_ARLEN = 4'(BURST_LEN - 1);
    localparam logic [31:0] LINE_MASK  = ~(32'(BURST_LEN * 4) - 32'd1);

    rd_state_t r_rd_state, w_rd_state_nx;
    wr_state_t r_wr_state, w_wr_state_nx;

    logic            r_rd_src_data;   // 1: outstanding read belongs to the data port
    logic [ID_W-1:0] r_arid;
    logic [31:0]     r_araddr;
    logic [3:0]      r_arlen;
    logic [2:0]      r_arsize;
    logic [1:0]      r_arburst;
    logic [31:0]     r_awaddr;
    logic [2:0]      r_awsize;
    logic [31:0]     r_wdata;
    logic [3:0]      r_wstrb;
    logic            r_aw_done, r_w_done;
    logic            w_aw_done_nx, w_w_done_nx;
    logic            w_inst_acc, w_drd_acc, w_wr_acc;
    logic            w_unused;

    // Response ids/codes are not used: the stored source routes read beats.
    assign w_unused = ^{rid, rresp, bid, bresp, inst_addr[1:0]};

    // ---------------- read FSM ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_rd_state <= R_IDLE;
        else          r_rd_state <= w_rd_state_nx;
    end

    always_comb begin
        w_rd_state_nx = r_rd_state;
        w_inst_acc    = 1'b0;
        w_drd_acc     = 1'b0;
        arvalid       = 1'b0;
        rready        = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                // A data read waits for the write engine to drain so it can
                // never overtake an earlier write to the same location.
                if (data_req && !data_wr && (r_wr_state == W_IDLE)) begin
                    w_drd_acc     = 1'b1;
                    w_rd_state_nx = R_AR;
                end else if (inst_req) begin
                    w_inst_acc    = 1'b1;
                    w_rd_state_nx = R_AR;
                end
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) w_rd_state_nx = R_DATA;
            end
            R_DATA: begin
                rready = 1'b1;
                if (rvalid && rlast) w_rd_state_nx = R_IDLE;
            end
            default: w_rd_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_src_data <= 1'b0;
            r_arid        <= '0;
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_arsize      <= '0;
            r_arburst     <= '0;
        end else if (w_drd_acc) begin
            r_rd_src_data <= 1'b1;
            r_arid        <= ID_W'(1);
            r_araddr      <= data_addr;
            r_arlen       <= 4'd0;
            r_arsize      <= {1'b0, data_size};
            r_arburst     <= 2'b01;
        end else if (w_inst_acc) begin
            r_rd_src_data <= 1'b0;
            r_arid        <= '0;
            r_arlen       <= INST_ARLEN;
            r_arsize      <= 3'd2;
`ifdef AXI_BRIDGE_WRAP_EN
            r_araddr      <= {inst_addr[31:2], 2'b00};
            r_arburst     <= 2'b10;
`else
            r_araddr      <= inst_addr & LINE_MASK;
            r_arburst     <= 2'b01;
`endif
        end
    end

    assign inst_addr_ok = w_inst_acc;
    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arlen   = r_arlen;
    assign arsize  = r_arsize;
    assign arburst = r_arburst;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    // Zero-cycle forward of r beats to the port that issued the read.
    assign inst_rvalid = (r_rd_state == R_DATA) && !r_rd_src_data && rvalid;
    assign inst_rlast  = (r_rd_state == R_DATA) && !r_rd_src_data && rlast;
    assign inst_rdata  = ((r_rd_state == R_DATA) && !r_rd_src_data) ? rdata : '0;
    assign data_rvalid = (r_rd_state == R_DATA) && r_rd_src_data && rvalid;
    assign data_rdata  = ((r_rd_state == R_DATA) && r_rd_src_data) ? rdata : '0;

    // ---------------- write FSM ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_state <= W_IDLE;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nx;
            r_aw_done  <= w_aw_done_nx;
            r_w_done   <= w_w_done_nx;
        end
    end

    always_comb begin
        w_wr_state_nx = r_wr_state;
        w_aw_done_nx  = r_aw_done;
        w_w_done_nx   = r_w_done;
        w_wr_acc      = 1'b0;
        awvalid       = 1'b0;
        wvalid        = 1'b0;
        bready        = 1'b0;
        data_wdone    = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (data_req && data_wr) begin
                    w_wr_acc      = 1'b1;
                    w_wr_state_nx = W_SEND;
                end
            end
            W_SEND: begin
                // AW and W complete independently; move on once both have.
                awvalid = !r_aw_done;
                wvalid  = !r_w_done;
                if (!r_aw_done && awready) w_aw_done_nx = 1'b1;
                if (!r_w_done && wready)   w_w_done_nx  = 1'b1;
                if (w_aw_done_nx && w_w_done_nx) begin
                    w_aw_done_nx  = 1'b0;
                    w_w_done_nx   = 1'b0;
                    w_wr_state_nx = W_B;
                end
            end
            W_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_wdone    = 1'b1;
                    w_wr_state_nx = W_IDLE;
                end
            end
            default: w_wr_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_awaddr <= '0;
            r_awsize <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else if (w_wr_acc) begin
            r_awaddr <= data_addr;
            r_awsize <= {1'b0, data_size};
            r_wdata  <= data_wdata;
            r_wstrb  <= data_wstrb;
        end
    end

    assign data_addr_ok = w_drd_acc | w_wr_acc;
    // Ids read as 0 while no write is outstanding so reset shows all-zero ids.
    assign awid    = (r_wr_state == W_IDLE) ? '0 : ID_W'(1);
    assign wid     = (r_wr_state == W_IDLE) ? '0 : ID_W'(1);
    assign awaddr  = r_awaddr;
    assign awlen   = 4'd0;
    assign awsize  = r_awsize;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;

    assign o_dbg_rd_state = r_rd_state;
    assign o_dbg_wr_state = r_wr_state;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Testbench for cpu_axi_bridge. Inputs are driven 1 time unit after the
// falling edge; outputs are sampled 3 time units after the falling edge.
module tb_cpu_axi_bridge;
    localparam int BL = 8;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic inst_req, inst_addr_ok, inst_rvalid, inst_rlast;
    logic [31:0] inst_addr, inst_rdata;
    logic data_req, data_wr, data_addr_ok, data_rvalid, data_wdone;
    logic [1:0] data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0] data_wstrb;
    logic [3:0] arid, rid, awid, wid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [3:0] arlen, arcache, awlen, awcache, wstrb;
    logic [2:0] arsize, arprot, awsize, awprot;
    logic [1:0] arburst, arlock, rresp, awburst, awlock, bresp;
    logic arvalid, arready, rlast, rvalid, rready;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [1:0] o_dbg_rd_state, o_dbg_wr_state;

    always #5 aclk = ~aclk;

    cpu_axi_bridge #(.BURST_LEN(BL), .ID_W(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid), .inst_rlast(inst_rlast),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_rvalid(data_rvalid),
        .data_wdone(data_wdone),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .o_dbg_rd_state(o_dbg_rd_state), .o_dbg_wr_state(o_dbg_wr_state)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [32:0] inst_exp_q[$];   // {rlast, data}
    logic [31:0] data_exp_q[$];
    logic [44:0] ar_exp_q[$];     // {addr, len, size, burst, id}
    logic [70:0] wr_exp_q[$];     // {addr, data, strb, size}
    int inst_beats = 0;
    bit data_ret_seen = 1'b0;
    bit b_done = 1'b0;
    logic [31:0] last_araddr;
    logic [1:0] last_arburst;
    logic [7:0] last_wfields;     // {awsize, wstrb, wlast}

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [3:0] len,
                                              input logic [1:0] burst, input int i);
        logic [31:0] span, nxt;
        span = (32'(len) + 32'd1) * 32'd4 - 32'd1;
        nxt = a + 32'(i) * 32'd4;
        if (burst == 2'b10) return (a & ~span) | (nxt & span);
        return nxt;
    endfunction

    task automatic push_inst_exp(input logic [31:0] addr);
        logic [31:0] base;
        logic [1:0] burst;
`ifdef AXI_BRIDGE_WRAP_EN
        base = addr & ~32'd3;
        burst = 2'b10;
`else
        base = addr & ~(32'(BL * 4) - 32'd1);
        burst = 2'b01;
`endif
        ar_exp_q.push_back({base, 4'(BL - 1), 3'd2, burst, 4'd0});
        for (int i = 0; i < BL; i++)
            inst_exp_q.push_back({(i == BL - 1), mem(beat_addr(base, 4'(BL - 1), burst, i))});
    endtask

    task automatic push_dread_exp(input logic [31:0] addr, input logic [1:0] size);
        ar_exp_q.push_back({addr, 4'd0, {1'b0, size}, 2'b01, 4'd1});
        data_exp_q.push_back(mem(addr));
    endtask

    // ---------------- CPU-side drivers ----------------
    task automatic cpu_inst(input logic [31:0] addr, output int wait_cyc);
        push_inst_exp(addr);
        @(negedge aclk); #1;
        inst_req = 1'b1; inst_addr = addr; wait_cyc = 0;
        #2;
        while (!inst_addr_ok && wait_cyc < 300) begin @(negedge aclk); #3; wait_cyc++; end
        check_eq("inst_accept", 64'(inst_addr_ok), 64'd1);
        @(negedge aclk); #1;
        inst_req = 1'b0;
        check_eq("ar_latency", 64'(arvalid), 64'd1);
    endtask

    task automatic cpu_data_write(input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [3:0] strb, input logic [1:0] size, output int wait_cyc);
        wr_exp_q.push_back({addr, wd, strb, 1'b0, size});
        @(negedge aclk); #1;
        data_req = 1'b1; data_wr = 1'b1; data_addr = addr; data_wdata = wd;
        data_wstrb = strb; data_size = size; wait_cyc = 0;
        #2;
        while (!data_addr_ok && wait_cyc < 300) begin @(negedge aclk); #3; wait_cyc++; end
        check_eq("wr_accept", 64'(data_addr_ok), 64'd1);
        @(negedge aclk); #1;
        data_req = 1'b0;
        check_eq("aw_w_latency", 64'({awvalid, wvalid}), 64'd3);
    endtask

    // ---------------- AXI slave drivers ----------------
    task automatic slave_read(input int ar_delay, input int r_gap);
        int n;
        logic [44:0] e;
        logic [45:0] v;
        logic [31:0] a;
        logic [3:0] len, id;
        logic [1:0] burst;
        n = 0;
        @(negedge aclk); #1;
        while (!arvalid && n < 300) begin @(negedge aclk); #1; n++; end
        check_eq("ar_valid_seen", 64'(arvalid), 64'd1);
        a = araddr; len = arlen; burst = arburst; id = arid;
        last_araddr = araddr; last_arburst = arburst;
        v = {araddr, arlen, arsize, arburst, arid, arvalid};
        if (ar_exp_q.size() > 0) begin
            e = ar_exp_q.pop_front();
            check_eq("ar_fields", 64'({araddr, arlen, arsize, arburst, arid}), 64'(e));
        end else check_eq("ar_unexpected", 64'(ar_exp_q.size()), 64'd1);
        check_eq("ar_const", 64'({arlock, arcache, arprot}), 64'd0);
        repeat (ar_delay) begin
            @(negedge aclk); #1;
            check_eq("ar_hold", 64'({araddr, arlen, arsize, arburst, arid, arvalid}), 64'(v));
        end
        arready = 1'b1;
        @(negedge aclk); #1;
        arready = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            repeat (r_gap) begin @(negedge aclk); #1; end
            check_eq("rready", 64'(rready), 64'd1);
            rvalid = 1'b1; rid = id; rresp = 2'b00;
            rdata = mem(beat_addr(a, len, burst, i));
            rlast = (i == int'(len));
            @(negedge aclk); #1;
            rvalid = 1'b0; rlast = 1'b0;
        end
    endtask

    task automatic slave_write(input int aw_delay, input int w_delay, input int b_delay);
        int n, k, awc, wc;
        bit awd, wd;
        logic [70:0] e;
        logic [31:0] a;
        n = 0;
        @(negedge aclk); #1;
        while (!awvalid && n < 300) begin @(negedge aclk); #1; n++; end
        check_eq("aw_valid_seen", 64'({awvalid, wvalid}), 64'd3);
        last_wfields = {awsize, wstrb, wlast};
        if (wr_exp_q.size() > 0) begin
            e = wr_exp_q.pop_front();
            check_eq("aw_addr", 64'(awaddr), 64'(e[70:39]));
            check_eq("w_data", 64'(wdata), 64'(e[38:7]));
            check_eq("w_strb_size", 64'({wstrb, awsize}), 64'(e[6:0]));
        end else check_eq("wr_unexpected", 64'(wr_exp_q.size()), 64'd1);
        check_eq("aw_fixed", 64'({awid, wid, awlen, awburst, wlast, awlock, awcache, awprot}),
                 64'({4'd1, 4'd1, 4'd0, 2'b01, 1'b1, 9'd0}));
        a = awaddr;
        k = 0; awc = 0; wc = 0; awd = 1'b0; wd = 1'b0;
        while (!(awd && wd) && k < 100) begin
            awready = (k >= aw_delay);
            wready = (k >= w_delay);
            #2;
            check_eq("aw_w_valid", 64'({awvalid, wvalid}), 64'({!awd, !wd}));
            check_eq("aw_hold", 64'(awaddr), 64'(a));
            if (awvalid) awc++;
            if (wvalid) wc++;
            if (awvalid && awready) awd = 1'b1;
            if (wvalid && wready) wd = 1'b1;
            @(negedge aclk); #1;
            k++;
        end
        awready = 1'b0; wready = 1'b0;
        check_eq("awvalid_cycles", 64'(awc), 64'(aw_delay + 1));
        check_eq("wvalid_cycles", 64'(wc), 64'(w_delay + 1));
        repeat (b_delay) begin
            #2;
            check_eq("wdone_early", 64'({data_wdone, bready}), 64'd1);
            @(negedge aclk); #1;
        end
        bvalid = 1'b1; bid = 4'd1; bresp = 2'b00;
        #2;
        check_eq("wdone_pulse", 64'({data_wdone, bready}), 64'd3);
        @(negedge aclk); #1;
        bvalid = 1'b0; b_done = 1'b1;
        #2;
        check_eq("wdone_after", 64'({data_wdone, bready}), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge aclk) begin
        logic [32:0] ie;
        logic [31:0] de;
        #3;
        if (aresetn) begin
            if (inst_rvalid) begin
                inst_beats++;
                check_eq("rvalid_exclusive", 64'(data_rvalid), 64'd0);
                if (inst_exp_q.size() > 0) begin
                    ie = inst_exp_q.pop_front();
                    check_eq("inst_beat", 64'({inst_rlast, inst_rdata}), 64'(ie));
                end else check_eq("inst_extra_beat", 64'(inst_exp_q.size()), 64'd1);
            end
            if (data_rvalid) begin
                data_ret_seen = 1'b1;
                if (data_exp_q.size() > 0) begin
                    de = data_exp_q.pop_front();
                    check_eq("data_rdata", 64'(data_rdata), 64'(de));
                end else check_eq("data_extra_beat", 64'(data_exp_q.size()), 64'd1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, wc2, n, n2;
        logic [44:0] e;
        logic [31:0] a;
        inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
        data_addr = 0; data_wdata = 0; data_wstrb = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

        // Reset state
        repeat (3) @(negedge aclk);
        #3;
        check_eq("rst_ctrl", 64'({arvalid, awvalid, wvalid, rready, bready, inst_addr_ok,
                                  data_addr_ok, inst_rvalid, data_rvalid, data_wdone}), 64'd0);
        check_eq("rst_addr", 64'({araddr, awaddr}), 64'd0);
        check_eq("rst_ids", 64'({arid, awid, wid, wdata}), 64'd0);
        check_eq("rst_rdata", 64'({inst_rdata, data_rdata}), 64'd0);
        check_eq("rst_state", 64'({o_dbg_rd_state, o_dbg_wr_state}), 64'd0);
        @(negedge aclk); #1;
        aresetn = 1'b1;

        // Instruction line fill
        inst_beats = 0;
        fork
            cpu_inst(32'hBFC0_0014, wc);
            slave_read(2, 0);
        join
        check_eq("fill_beats", 64'(inst_beats), 64'(BL));
`ifdef AXI_BRIDGE_WRAP_EN
        check_eq("fill_araddr_burst", 64'({last_araddr, last_arburst}), 64'({32'hBFC0_0014, 2'b10}));
`else
        check_eq("fill_araddr_burst", 64'({last_araddr, last_arburst}), 64'({32'hBFC0_0000, 2'b01}));
`endif

        // Simultaneous data read and instruction fill: data wins
        data_ret_seen = 1'b0;
        push_dread_exp(32'h8000_0100, 2'd2);
        push_inst_exp(32'hBFC0_0040);
        fork
            begin
                @(negedge aclk); #1;
                inst_req = 1'b1; inst_addr = 32'hBFC0_0040;
                data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0100; data_size = 2'd2;
                #2;
                check_eq("arb_data_first", 64'({data_addr_ok, inst_addr_ok}), 64'd2);
                @(negedge aclk); #1;
                data_req = 1'b0;
                n = 0;
                #2;
                while (!inst_addr_ok && n < 300) begin @(negedge aclk); #3; n++; end
                check_eq("arb_inst_ok", 64'(inst_addr_ok), 64'd1);
                check_eq("arb_inst_after_rlast", 64'(data_ret_seen), 64'd1);
                @(negedge aclk); #1;
                inst_req = 1'b0;
            end
            begin
                slave_read(1, 0);
                slave_read(0, 1);
            end
        join

        // Write with awready delayed three cycles
        fork
            cpu_data_write(32'h8000_0010, 32'h1234_5678, 4'hF, 2'd2, wc);
            slave_write(3, 0, 2);
        join

        // Data read held off while the write waits in W_B
        b_done = 1'b0;
        fork
            begin
                cpu_data_write(32'h8000_0020, 32'hCAFE_F00D, 4'hF, 2'd2, wc);
                push_dread_exp(32'h8000_0200, 2'd2);
                data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0200; data_size = 2'd2;
                n = 0;
                #2;
                while (n < 50) begin
                    check_eq("raw_ok_tracks_b", 64'(data_addr_ok), 64'(b_done));
                    if (data_addr_ok) break;
                    @(negedge aclk); #3;
                    n++;
                end
                @(negedge aclk); #1;
                data_req = 1'b0;
            end
            begin
                slave_write(0, 0, 4);
                slave_read(0, 0);
            end
        join

        // Byte write
        fork
            cpu_data_write(32'h8000_0202, 32'h00AB_0000, 4'b0100, 2'd0, wc);
            slave_write(0, 1, 0);
        join
        check_eq("byte_write_fields", 64'(last_wfields), 64'({3'd0, 4'b0100, 1'b1}));

        // Data write accepted while an instruction fill is in R_DATA
        fork
            cpu_inst(32'h0000_1000, wc);
            slave_read(0, 2);
            begin
                n2 = 0;
                @(negedge aclk); #1;
                while (!rready && n2 < 300) begin @(negedge aclk); #1; n2++; end
                check_eq("fill_in_rdata", 64'(rready), 64'd1);
                cpu_data_write(32'h8000_0300, 32'h0BAD_BEEF, 4'hF, 2'd2, wc2);
                check_eq("wr_during_fill_first_cycle", 64'(wc2), 64'd0);
            end
            slave_write(1, 0, 1);
        join

        // Reset asserted mid-burst
        fork
            cpu_inst(32'h0000_2000, wc);
            begin
                n = 0;
                @(negedge aclk); #1;
                while (!arvalid && n < 300) begin @(negedge aclk); #1; n++; end
                check_eq("rst_ar_seen", 64'(arvalid), 64'd1);
                a = araddr;
                if (ar_exp_q.size() > 0) begin
                    e = ar_exp_q.pop_front();
                    check_eq("rst_ar_fields", 64'({araddr, arlen, arsize, arburst, arid}), 64'(e));
                end else check_eq("rst_ar_unexpected", 64'(ar_exp_q.size()), 64'd1);
                arready = 1'b1;
                @(negedge aclk); #1;
                arready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    rvalid = 1'b1; rlast = 1'b0;
                    rdata = mem(beat_addr(a, 4'(BL - 1), last_arburst, i));
                    @(negedge aclk); #1;
                end
            end
        join
        rvalid = 1'b1;
        aresetn = 1'b0;
        #1;
        check_eq("rst_mid_ctrl", 64'({rready, arvalid, inst_rvalid, inst_addr_ok}), 64'd0);
        check_eq("rst_mid_state", 64'({o_dbg_rd_state, o_dbg_wr_state}), 64'd0);
        rvalid = 1'b0;
        @(negedge aclk); #1;
        aresetn = 1'b1;
        inst_exp_q.delete();
        fork
            cpu_inst(32'h0000_3008, wc);
            slave_read(0, 0);
        join
        check_eq("post_rst_first_cycle", 64'(wc), 64'd0);

        repeat (3) @(negedge aclk);
        check_eq("queues_empty", 64'(inst_exp_q.size() + data_exp_q.size() +
                                     ar_exp_q.size() + wr_exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
